pss_sched: RTL and testbench
============================

# pss_sched

Sequencer for the point-sort-select (PSS) array. Each center-point pass runs the same steps:
- load NUM_SORT_CORE neighbour masks from FPS into PSS;
- stream one center's list of points (LOP) from KNN into PSS and flag the last element;
- wait until the sorted map words have drained to CTR;
- reset PSS and advance the center index.

The block sits between CTR, FPS, KNN and PSS. It owns the PSS control handshakes, not the wide data buses, which are wired directly.

## Interface
Parameters:
- IDX_WIDTH, 10, point/center index width
- NUM_SORT_CORE, 8, sort cores in PSS; masks per pass and map words per pass

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- CTRPSC_Start  in  1  one-cycle start pulse
- CTRPSC_NumPnt  in  IDX_WIDTH  LOP elements per center; sampled at Start
- CTRPSC_NumCp  in  IDX_WIDTH  centers per job; sampled at Start
- PSCCTR_Busy  out  1  high from accepted Start until Done
- PSCCTR_Done  out  1  one-cycle job-complete pulse
- FPSPSC_MaskVld  in  1  mask valid from FPS
- PSCFPS_MaskRdy  out  1  mask ready to FPS
- PSCPSS_MaskVld  out  1  gated mask valid to PSS
- PSSPSC_MaskRdy  in  1  PSS mask ready
- KNNPSC_LopVld  in  1  LOP valid from KNN
- PSCKNN_LopRdy  out  1  LOP ready to KNN
- PSCPSS_LopVld  out  1  gated LOP valid to PSS
- PSSPSC_LopRdy  in  1  PSS LOP ready
- PSCPSS_LopLast  out  1  marks final LOP of the current center
- PSCPSS_Rst  out  1  one-cycle PSS soft reset (mask address clear)
- PSCPSS_CpIdx  out  IDX_WIDTH  current center index
- PSSCTR_MapVld  in  1  map word valid (monitored)
- CTRPSS_MapRdy  in  1  map word ready (monitored)

## Operation
States: IDLE, LDMASK, STREAM, DRAIN, NEXT.

- **IDLE**
  - Start with NumPnt≠0 and NumCp≠0: latch both, clear cp_idx, pulse PSCPSS_Rst, go to LDMASK.
  - Start with either value 0: PSCCTR_Done pulses next cycle; state stays IDLE; Busy stays 0.
- **LDMASK**
  - PSCPSS_MaskVld = FPSPSC_MaskVld.
  - PSCFPS_MaskRdy = PSSPSC_MaskRdy.
  - mask_cnt counts handshakes (Vld&Rdy). After NUM_SORT_CORE handshakes, go to STREAM.
- **STREAM**
  - PSCPSS_LopVld = KNNPSC_LopVld.
  - PSCKNN_LopRdy = PSSPSC_LopRdy.
  - PSCPSS_LopLast = (lop_cnt == NumPnt-1), combinational.
  - The handshake on the last element moves the FSM to DRAIN.
- **DRAIN**
  - map_cnt counts PSSCTR_MapVld&CTRPSS_MapRdy.
  - After NUM_SORT_CORE map words, go to NEXT.
- **NEXT** (one cycle)
  - Pulse PSCPSS_Rst and clear all counters.
  - If cp_idx == NumCp-1: pulse Done and go to IDLE.
  - Otherwise: cp_idx+1, go to LDMASK.

Rules in every state:
- All forwarded valid/ready pairs are 0 outside their own state; upstream is stalled, never dropped.
- Map handshakes outside DRAIN are not counted.
- Start while Busy is ignored.
- Counters: mask_cnt and map_cnt are $clog2(NUM_SORT_CORE)+1 bits; lop_cnt is IDX_WIDTH bits. The NumPnt-1 and NumCp-1 compares use IDX_WIDTH bits; the value 0 is excluded at Start.

## Timing
- **Reset:** state IDLE, all counters 0. Every output 0, including CpIdx, Busy, Done and Rst.
- **Start:** Busy rises in the cycle after Start. Rst pulses in that same cycle.
- **Pass-through paths** (mask and LOP valid/ready, LopLast): combinational, zero-cycle.
- **State changes:** registered. The handshake that completes a phase switches state at the next edge. No handshake of the next phase can occur in that same cycle.
- **Pass overhead:** one NEXT cycle between the last map word and the next LDMASK.
- **Done:** asserted in the NEXT cycle of the final center. Busy falls in the following cycle.
- **CpIdx:** registered, updated at the NEXT→LDMASK edge, stable for the whole pass.
- **rst_n mid-job:** immediate abort to the reset state. No Done is issued.

## Structure
- Shared package holds:
  - state encoding (localparam enum, 3 bits);
  - PSC_CNT_W = $clog2(NUM_SORT_CORE)+1.
- Single flat module, no sub-modules.
- A generic handshake counter helper (cnt_en = vld&rdy, terminal compare) may be factored out as `hs_cnt`.

## Test plan
- **Full job:** NumPnt=5, NumCp=2, NUM_SORT_CORE=8, all readies high. Expect:
  - 8 mask handshakes, then 5 LOP handshakes with LopLast only on the 5th;
  - 8 map words, then CpIdx=1, then the same sequence again;
  - Done exactly once; Rst pulses = 3 (Start + 2×NEXT).
- **Backpressure:** random PSSPSC_MaskRdy, PSSPSC_LopRdy and CTRPSS_MapRdy at 50%. Expect identical handshake counts, and no Vld&Rdy leakage into a phase other than the active one.
- **Zero config:** Start with NumPnt=0. Expect Done one cycle later, Busy never 1, no Rst pulse.
- **Start while busy:** second Start during STREAM. Expect it ignored; latched NumPnt and NumCp unchanged.
- **Early map traffic:** MapVld&Rdy toggled during LDMASK. Expect map_cnt unaffected; DRAIN still needs 8 words.
- **Mid-job reset:** rst_n low during DRAIN of center 0. Expect all outputs 0 immediately; a new Start then runs normally from CpIdx=0.

Source files
------------

// File: rtl/pss_sched_pkg.sv
// Shared definitions for the PSS sequencer: pass-phase encoding and
// handshake counter sizing.
package pss_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LDMASK = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    NEXT   = 3'd4
  } psc_state_t;

  localparam int DEF_NUM_SORT_CORE = 8;
  localparam int PSC_CNT_W         = $clog2(DEF_NUM_SORT_CORE) + 1;

  // Counter wide enough to hold the full count of sort-core words.
  function automatic int psc_cnt_w(input int num_sort_core);
    return $clog2(num_sort_core) + 1;
  endfunction

endpackage

// File: rtl/pss_sched_if.sv
// Control handshakes between CTR, FPS, KNN, PSS and the PSS sequencer.
// master = sequencer side, slave = surrounding blocks.
interface pss_sched_if #(
  parameter int IDX_WIDTH = 10
);
  logic                 CTRPSC_Start;
  logic [IDX_WIDTH-1:0] CTRPSC_NumPnt;
  logic [IDX_WIDTH-1:0] CTRPSC_NumCp;
  logic                 PSCCTR_Busy;
  logic                 PSCCTR_Done;
  logic                 FPSPSC_MaskVld;
  logic                 PSCFPS_MaskRdy;
  logic                 PSCPSS_MaskVld;
  logic                 PSSPSC_MaskRdy;
  logic                 KNNPSC_LopVld;
  logic                 PSCKNN_LopRdy;
  logic                 PSCPSS_LopVld;
  logic                 PSSPSC_LopRdy;
  logic                 PSCPSS_LopLast;
  logic                 PSCPSS_Rst;
  logic [IDX_WIDTH-1:0] PSCPSS_CpIdx;
  logic                 PSSCTR_MapVld;
  logic                 CTRPSS_MapRdy;

  modport master (
    input  CTRPSC_Start, CTRPSC_NumPnt, CTRPSC_NumCp,
    input  FPSPSC_MaskVld, PSSPSC_MaskRdy,
    input  KNNPSC_LopVld, PSSPSC_LopRdy,
    input  PSSCTR_MapVld, CTRPSS_MapRdy,
    output PSCCTR_Busy, PSCCTR_Done,
    output PSCFPS_MaskRdy, PSCPSS_MaskVld,
    output PSCKNN_LopRdy, PSCPSS_LopVld, PSCPSS_LopLast,
    output PSCPSS_Rst, PSCPSS_CpIdx
  );

  modport slave (
    output CTRPSC_Start, CTRPSC_NumPnt, CTRPSC_NumCp,
    output FPSPSC_MaskVld, PSSPSC_MaskRdy,
    output KNNPSC_LopVld, PSSPSC_LopRdy,
    output PSSCTR_MapVld, CTRPSS_MapRdy,
    input  PSCCTR_Busy, PSCCTR_Done,
    input  PSCFPS_MaskRdy, PSCPSS_MaskVld,
    input  PSCKNN_LopRdy, PSCPSS_LopVld, PSCPSS_LopLast,
    input  PSCPSS_Rst, PSCPSS_CpIdx
  );

endinterface

// File: rtl/pss_sched.sv
// PSS sequencer: per center, load masks, stream the LOP, wait for the map
// words to drain, then soft-reset PSS and move to the next center.
module pss_sched
  import pss_sched_pkg::*;
#(
  parameter int IDX_WIDTH     = 10,
  parameter int NUM_SORT_CORE = 8
) (
  input logic         clk,
  input logic         rst_n,
  pss_sched_if.master bus
);

  localparam int               CNT_W    = psc_cnt_w(NUM_SORT_CORE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SORT_CORE - 1);

  psc_state_t           state;
  psc_state_t           state_nxt;
  logic [CNT_W-1:0]     mask_cnt;
  logic [CNT_W-1:0]     map_cnt;
  logic [IDX_WIDTH-1:0] lop_cnt;
  logic [IDX_WIDTH-1:0] cp_idx;
  logic [IDX_WIDTH-1:0] num_pnt;
  logic [IDX_WIDTH-1:0] num_cp;
  logic                 rst_pend;
  logic                 done_zero;

  logic start_ok;
  logic start_zero;
  logic mask_hs;
  logic lop_hs;
  logic map_hs;
  logic lop_last;
  logic cp_last;

  // A start with a zero count is acknowledged with Done but never runs.
  assign start_ok   = (state == IDLE) && bus.CTRPSC_Start &&
                      (|bus.CTRPSC_NumPnt) && (|bus.CTRPSC_NumCp);
  assign start_zero = (state == IDLE) && bus.CTRPSC_Start && !start_ok;
  assign mask_hs    = (state == LDMASK) && bus.FPSPSC_MaskVld && bus.PSSPSC_MaskRdy;
  assign lop_hs     = (state == STREAM) && bus.KNNPSC_LopVld && bus.PSSPSC_LopRdy;
  assign map_hs     = (state == DRAIN) && bus.PSSCTR_MapVld && bus.CTRPSS_MapRdy;
  assign lop_last   = (lop_cnt == num_pnt - IDX_WIDTH'(1));
  assign cp_last    = (cp_idx == num_cp - IDX_WIDTH'(1));

  always_comb begin
    state_nxt          = state;
    bus.PSCPSS_MaskVld = 1'b0;
    bus.PSCFPS_MaskRdy = 1'b0;
    bus.PSCPSS_LopVld  = 1'b0;
    bus.PSCKNN_LopRdy  = 1'b0;
    bus.PSCPSS_LopLast = 1'b0;
    bus.PSCCTR_Busy    = (state != IDLE);
    bus.PSCCTR_Done    = done_zero;
    bus.PSCPSS_Rst     = rst_pend;
    bus.PSCPSS_CpIdx   = cp_idx;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = LDMASK;
      end
      LDMASK: begin
        bus.PSCPSS_MaskVld = bus.FPSPSC_MaskVld;
        bus.PSCFPS_MaskRdy = bus.PSSPSC_MaskRdy;
        if (mask_hs && (mask_cnt == CNT_LAST)) state_nxt = STREAM;
      end
      STREAM: begin
        bus.PSCPSS_LopVld  = bus.KNNPSC_LopVld;
        bus.PSCKNN_LopRdy  = bus.PSSPSC_LopRdy;
        bus.PSCPSS_LopLast = lop_last;
        if (lop_hs && lop_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (map_hs && (map_cnt == CNT_LAST)) state_nxt = NEXT;
      end
      NEXT: begin
        bus.PSCPSS_Rst = 1'b1;
        if (cp_last) bus.PSCCTR_Done = 1'b1;
        state_nxt = cp_last ? IDLE : LDMASK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters only advance inside their own phase and are wiped in NEXT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask_cnt  <= '0;
      map_cnt   <= '0;
      lop_cnt   <= '0;
      cp_idx    <= '0;
      num_pnt   <= '0;
      num_cp    <= '0;
      rst_pend  <= 1'b0;
      done_zero <= 1'b0;
    end else begin
      state     <= state_nxt;
      rst_pend  <= start_ok;
      done_zero <= start_zero;
      if (start_ok) begin
        num_pnt <= bus.CTRPSC_NumPnt;
        num_cp  <= bus.CTRPSC_NumCp;
        cp_idx  <= '0;
      end else if ((state == NEXT) && !cp_last) begin
        cp_idx <= cp_idx + IDX_WIDTH'(1);
      end
      if (state == NEXT) begin
        mask_cnt <= '0;
        map_cnt  <= '0;
        lop_cnt  <= '0;
      end else begin
        if (mask_hs) mask_cnt <= mask_cnt + CNT_W'(1);
        if (map_hs)  map_cnt  <= map_cnt + CNT_W'(1);
        if (lop_hs)  lop_cnt  <= lop_cnt + IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pss_sched.sv
// Self-checking bench for pss_sched: a scripted per-center expectation walks
// each job cycle by cycle while random upstream/downstream traffic runs.
module tb_pss_sched;

  localparam int IDX_WIDTH = 10;
  localparam int NSC       = 8;
  localparam int BUDGET    = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pss_sched_if #(.IDX_WIDTH(IDX_WIDTH)) bus ();

  pss_sched #(.IDX_WIDTH(IDX_WIDTH), .NUM_SORT_CORE(NSC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit randMode = 1'b0;
  int rstSeen, doneSeen, maskHsSeen, lopHsSeen, lastSeen;

  // Event totals seen at the PSS/CTR side, compared against job arithmetic.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.PSCPSS_Rst) rstSeen++;
      if (bus.PSCCTR_Done) doneSeen++;
      if (bus.PSCPSS_MaskVld && bus.PSSPSC_MaskRdy) maskHsSeen++;
      if (bus.PSCPSS_LopVld && bus.PSSPSC_LopRdy) begin
        lopHsSeen++;
        if (bus.PSCPSS_LopLast) lastSeen++;
      end
    end
  end

  // FPS/KNN/PSS/CTR traffic: all asserted, or 50% random each cycle.
  initial begin
    bus.FPSPSC_MaskVld = 1'b0;
    bus.PSSPSC_MaskRdy = 1'b0;
    bus.KNNPSC_LopVld  = 1'b0;
    bus.PSSPSC_LopRdy  = 1'b0;
    bus.PSSCTR_MapVld  = 1'b0;
    bus.CTRPSS_MapRdy  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (randMode) begin
        bus.FPSPSC_MaskVld = 1'($urandom_range(0, 1));
        bus.PSSPSC_MaskRdy = 1'($urandom_range(0, 1));
        bus.KNNPSC_LopVld  = 1'($urandom_range(0, 1));
        bus.PSSPSC_LopRdy  = 1'($urandom_range(0, 1));
        bus.PSSCTR_MapVld  = 1'($urandom_range(0, 1));
        bus.CTRPSS_MapRdy  = 1'($urandom_range(0, 1));
      end else begin
        bus.FPSPSC_MaskVld = 1'b1;
        bus.PSSPSC_MaskRdy = 1'b1;
        bus.KNNPSC_LopVld  = 1'b1;
        bus.PSSPSC_LopRdy  = 1'b1;
        bus.PSSCTR_MapVld  = 1'b1;
        bus.CTRPSS_MapRdy  = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkPaths(input bit inMask, input bit inLop, input bit expLast);
    checkOutput("mask_vld", bus.PSCPSS_MaskVld, inMask ? bus.FPSPSC_MaskVld : 1'b0);
    checkOutput("mask_rdy", bus.PSCFPS_MaskRdy, inMask ? bus.PSSPSC_MaskRdy : 1'b0);
    checkOutput("lop_vld", bus.PSCPSS_LopVld, inLop ? bus.KNNPSC_LopVld : 1'b0);
    checkOutput("lop_rdy", bus.PSCKNN_LopRdy, inLop ? bus.PSSPSC_LopRdy : 1'b0);
    checkOutput("lop_last", bus.PSCPSS_LopLast, expLast);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, bus.PSCCTR_Busy, 0);
    checkOutput({tag, "_done"}, bus.PSCCTR_Done, 0);
    checkOutput({tag, "_rst"}, bus.PSCPSS_Rst, 0);
    checkOutput({tag, "_cpidx"}, bus.PSCPSS_CpIdx, 0);
    checkPaths(1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetCounters();
    rstSeen = 0;
    doneSeen = 0;
    maskHsSeen = 0;
    lopHsSeen = 0;
    lastSeen = 0;
  endtask

  // Pulses Start for one cycle, then scrambles the count inputs.
  task automatic applyStimulus(input int np, input int nc);
    @(posedge clk);
    #1;
    bus.CTRPSC_Start  = 1'b1;
    bus.CTRPSC_NumPnt = IDX_WIDTH'(np);
    bus.CTRPSC_NumCp  = IDX_WIDTH'(nc);
    @(posedge clk);
    #1;
    bus.CTRPSC_Start  = 1'b0;
    bus.CTRPSC_NumPnt = IDX_WIDTH'($urandom);
    bus.CTRPSC_NumCp  = IDX_WIDTH'($urandom);
  endtask

  // Expected job: per center NSC masks, np LOPs (last flagged), NSC map words
  // counted from the cycle after the last LOP, then one NEXT cycle.
  task automatic checkJob(input int np, input int nc, input int abortCenter, input bit injectStart);
    int cnt;
    int cyc;
    for (int c = 0; c < nc; c++) begin
      cnt = 0;
      cyc = 0;
      while (cnt < NSC && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
        checkPaths(1'b1, 1'b0, 1'b0);
        checkOutput("ldmask_rst", bus.PSCPSS_Rst, (cyc == 1 && c == 0));
        checkOutput("ldmask_cpidx", bus.PSCPSS_CpIdx, c);
        checkOutput("ldmask_busy", bus.PSCCTR_Busy, 1);
        checkOutput("ldmask_done", bus.PSCCTR_Done, 0);
        if (bus.FPSPSC_MaskVld && bus.PSSPSC_MaskRdy) cnt++;
      end
      checkOutput("ldmask_timeout", cnt, NSC);
      if (cnt != NSC) return;

      cnt = 0;
      cyc = 0;
      while (cnt < np && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
        checkPaths(1'b0, 1'b1, (cnt == np - 1));
        checkOutput("stream_cpidx", bus.PSCPSS_CpIdx, c);
        checkOutput("stream_rst", bus.PSCPSS_Rst, 0);
        checkOutput("stream_busy", bus.PSCCTR_Busy, 1);
        if (bus.KNNPSC_LopVld && bus.PSSPSC_LopRdy) cnt++;
        if (injectStart && c == 0 && cyc == 1) begin
          bus.CTRPSC_Start  = 1'b1;
          bus.CTRPSC_NumPnt = IDX_WIDTH'(np + 3);
          bus.CTRPSC_NumCp  = IDX_WIDTH'(nc + 2);
        end else begin
          bus.CTRPSC_Start = 1'b0;
        end
      end
      checkOutput("stream_timeout", cnt, np);
      if (cnt != np) return;

      cnt = 0;
      cyc = 0;
      while (cnt < NSC && cyc < BUDGET) begin
        @(negedge clk);
        cyc++;
        bus.CTRPSC_Start = 1'b0;
        checkPaths(1'b0, 1'b0, 1'b0);
        checkOutput("drain_rst", bus.PSCPSS_Rst, 0);
        checkOutput("drain_cpidx", bus.PSCPSS_CpIdx, c);
        if (c == abortCenter && cyc == 3) begin
          rst_n = 1'b0;
          #1;
          checkAllZero("abort");
          return;
        end
        if (bus.PSSCTR_MapVld && bus.CTRPSS_MapRdy) cnt++;
      end
      checkOutput("drain_timeout", cnt, NSC);
      if (cnt != NSC) return;

      @(negedge clk);
      checkPaths(1'b0, 1'b0, 1'b0);
      checkOutput("next_rst", bus.PSCPSS_Rst, 1);
      checkOutput("next_done", bus.PSCCTR_Done, (c == nc - 1));
      checkOutput("next_busy", bus.PSCCTR_Busy, 1);
      checkOutput("next_cpidx", bus.PSCPSS_CpIdx, c);
    end
    @(negedge clk);
    checkOutput("end_busy", bus.PSCCTR_Busy, 0);
    checkOutput("end_done", bus.PSCCTR_Done, 0);
    checkOutput("end_rst", bus.PSCPSS_Rst, 0);
  endtask

  task automatic checkTotals(input int np, input int nc);
    checkOutput("tot_mask", maskHsSeen, NSC * nc);
    checkOutput("tot_lop", lopHsSeen, np * nc);
    checkOutput("tot_last", lastSeen, nc);
    checkOutput("tot_rst", rstSeen, nc + 1);
    checkOutput("tot_done", doneSeen, 1);
  endtask

  initial begin
    int np;
    int nc;
    bus.CTRPSC_Start  = 1'b0;
    bus.CTRPSC_NumPnt = '0;
    bus.CTRPSC_NumCp  = '0;
    resetCounters();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] full job NumPnt=5 NumCp=2");
    resetCounters();
    applyStimulus(5, 2);
    checkJob(5, 2, -1, 1'b0);
    checkTotals(5, 2);

    $display("[TB] single point, single center");
    resetCounters();
    applyStimulus(1, 1);
    checkJob(1, 1, -1, 1'b0);
    checkTotals(1, 1);

    $display("[TB] zero configurations");
    for (int z = 0; z < 2; z++) begin
      resetCounters();
      applyStimulus(z == 0 ? 0 : 4, z == 0 ? 3 : 0);
      @(negedge clk);
      checkOutput("zero_done", bus.PSCCTR_Done, 1);
      checkOutput("zero_busy", bus.PSCCTR_Busy, 0);
      checkOutput("zero_rst", bus.PSCPSS_Rst, 0);
      repeat (3) begin
        @(negedge clk);
        checkOutput("zero_after_done", bus.PSCCTR_Done, 0);
        checkOutput("zero_after_busy", bus.PSCCTR_Busy, 0);
        checkPaths(1'b0, 1'b0, 1'b0);
      end
      checkOutput("zero_tot_rst", rstSeen, 0);
      checkOutput("zero_tot_done", doneSeen, 1);
    end

    $display("[TB] start while busy");
    resetCounters();
    applyStimulus(4, 2);
    checkJob(4, 2, -1, 1'b1);
    checkTotals(4, 2);

    $display("[TB] random backpressure");
    randMode = 1'b1;
    for (int j = 0; j < 5; j++) begin
      np = $urandom_range(1, 20);
      nc = $urandom_range(1, 3);
      resetCounters();
      applyStimulus(np, nc);
      checkJob(np, nc, -1, 1'b0);
      checkTotals(np, nc);
    end
    randMode = 1'b0;

    $display("[TB] mid-job reset");
    for (int a = 0; a < 2; a++) begin
      applyStimulus(3, 3);
      checkJob(3, 3, a, 1'b0);
      repeat (2) @(negedge clk);
      checkAllZero("held_reset");
      rst_n = 1'b1;
      resetCounters();
      applyStimulus(3, 2);
      checkJob(3, 2, -1, 1'b0);
      checkTotals(3, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
